// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds conditioned operands, S2 holds the registered result and flags.
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Cout,
    output logic             Z
);

    logic               s1_v_r;
    logic               s2_v_r;
    logic [WIDTH-1:0]   s1_a_r;
    logic [WIDTH-1:0]   s1_b_r;
    logic               s1_cin_r;
    logic               s1_sign_r;
    logic [2:0]         s1_op_r;

    logic               s2_load_s;
    logic               s1_load_s;
    logic               accept_s;
    logic [SHAMT_W-1:0] sh_s;
    logic [2*WIDTH-1:0] rot_wide_s;
    logic [WIDTH-1:0]   sra_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   res_s;
    logic               ofl_s;
    logic               cout_s;

    // A stage may load when it is empty or its contents move on this edge.
    assign s2_load_s = !s2_v_r || out_ready;
    assign s1_load_s = !s1_v_r || s2_load_s;
    assign in_ready  = !rst && s1_load_s;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = s2_v_r;

    // Upper half of the doubled operand shifted left is the left rotation.
    assign sh_s       = s1_b_r[SHAMT_W-1:0];
    assign rot_wide_s = {s1_a_r, s1_a_r} << sh_s;
    assign sra_s      = $signed(s1_a_r) >>> sh_s;
    assign sum_s      = {1'b0, s1_a_r} + {1'b0, s1_b_r} + {{WIDTH{1'b0}}, s1_cin_r};

    // Result and flag selection from the S1 contents.
    always_comb begin
        res_s  = {WIDTH{1'b0}};
        ofl_s  = 1'b0;
        cout_s = 1'b0;
        case (s1_op_r)
            3'b000: res_s = rot_wide_s[2*WIDTH-1:WIDTH];
            3'b001: res_s = s1_a_r << sh_s;
            3'b010: res_s = sra_s;
            3'b011: res_s = s1_a_r >> sh_s;
            3'b100: begin
                res_s  = sum_s[WIDTH-1:0];
                cout_s = sum_s[WIDTH];
                if (s1_sign_r) begin
                    ofl_s = (s1_a_r[WIDTH-1] == s1_b_r[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != s1_a_r[WIDTH-1]);
                end else begin
                    ofl_s = sum_s[WIDTH];
                end
            end
            3'b101: res_s = s1_a_r | s1_b_r;
            3'b110: res_s = s1_a_r ^ s1_b_r;
            3'b111: res_s = s1_a_r & s1_b_r;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Stage 1: capture conditioned operands on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r    <= 1'b0;
            s1_a_r    <= {WIDTH{1'b0}};
            s1_b_r    <= {WIDTH{1'b0}};
            s1_cin_r  <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_op_r   <= 3'b000;
        end else if (s1_load_s) begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_a_r    <= invA ? ~A : A;
                s1_b_r    <= invB ? ~B : B;
                s1_cin_r  <= Cin;
                s1_sign_r <= sign;
                s1_op_r   <= Op;
            end
        end
    end

    // Stage 2: register the result; it holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_r <= 1'b0;
            Out    <= {WIDTH{1'b0}};
            Ofl    <= 1'b0;
            Cout   <= 1'b0;
            Z      <= 1'b0;
        end else if (s2_load_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                Out  <= res_s;
                Ofl  <= ofl_s;
                Cout <= cout_s;
                Z    <= (res_s == {WIDTH{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized traffic on a 16-bit
// and a 32-bit instance, scored against a bit-level arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b0, cin16 = 1'b0, ia16 = 1'b0, ib16 = 1'b0, sg16 = 1'b0;
    logic [15:0] a16 = 16'h0, b16 = 16'h0, out16;
    logic [2:0]  op16 = 3'd0;
    logic        ofl16, co16, z16;

    logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b0, cin32 = 1'b0, ia32 = 1'b0, ib32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = 32'h0, b32 = 32'h0, out32;
    logic [2:0]  op32 = 3'd0;
    logic        ofl32, co32, z32;

    logic [34:0] q16[$];
    logic [34:0] q32[$];
    logic        acc16 = 1'b0, acc32 = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .SHAMT_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .Cin(cin16), .Op(op16), .invA(ia16), .invB(ib16), .sign(sg16),
        .out_valid(ov16), .out_ready(ordy16), .Out(out16), .Ofl(ofl16), .Cout(co16), .Z(z16)
    );

    alu_pipe #(.WIDTH(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
        .Cin(cin32), .Op(op32), .invA(ia32), .invB(ib32), .sign(sg32),
        .out_valid(ov32), .out_ready(ordy32), .Out(out32), .Ofl(ofl32), .Cout(co32), .Z(z32)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: returns {Ofl, Cout, Z, Out[31:0]} for a w-bit datapath.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic [2:0] op,
                                          input logic ia, input logic ib, input logic sg);
        logic [63:0] mask, ap, bp, s;
        logic [31:0] o;
        logic        cout, ofl;
        int          sh;
        longint      sa, sb, ss, maxv, minv;
        mask = (64'd1 << w) - 64'd1;
        ap = {32'd0, a} & mask;
        bp = {32'd0, b} & mask;
        if (ia) ap = ~ap & mask;
        if (ib) bp = ~bp & mask;
        sh = int'(bp % 64'(w));
        o = 32'd0; cout = 1'b0; ofl = 1'b0;
        case (op)
            3'd0: for (int i = 0; i < w; i++) o[(i + sh) % w] = ap[i];
            3'd1: for (int i = 0; i < w; i++) if (i >= sh) o[i] = ap[i - sh];
            3'd2: for (int i = 0; i < w; i++) o[i] = (i + sh < w) ? ap[i + sh] : ap[w - 1];
            3'd3: for (int i = 0; i < w; i++) if (i + sh < w) o[i] = ap[i + sh];
            3'd4: begin
                s = ap + bp + {63'd0, cin};
                o = s[31:0] & mask[31:0];
                cout = s[w];
                if (sg) begin
                    sa = longint'(ap); if (ap[w - 1]) sa = sa - (longint'(1) << w);
                    sb = longint'(bp); if (bp[w - 1]) sb = sb - (longint'(1) << w);
                    ss = sa + sb + longint'(cin);
                    maxv = (longint'(1) << (w - 1)) - 1;
                    minv = -(longint'(1) << (w - 1));
                    ofl = (ss > maxv) || (ss < minv);
                end else begin
                    ofl = cout;
                end
            end
            3'd5: o = ap[31:0] | bp[31:0];
            3'd6: o = ap[31:0] ^ bp[31:0];
            3'd7: o = ap[31:0] & bp[31:0];
            default: o = 32'd0;
        endcase
        return {ofl, cout, (o == 32'd0), o};
    endfunction

    // Scoreboard for one instance: checks any visible result, records transfers.
    task automatic mon(input int d);
        logic        iv, ir, ov, ordy, ofl, co, z, ci, ia, ib, sg;
        logic [31:0] o, a, b;
        logic [2:0]  op;
        logic [34:0] e;
        int          w, n;
        if (d == 0) begin
            w = 16; iv = iv16; ir = ir16; ov = ov16; ordy = ordy16; o = {16'h0, out16};
            ofl = ofl16; co = co16; z = z16; a = {16'h0, a16}; b = {16'h0, b16};
            ci = cin16; op = op16; ia = ia16; ib = ib16; sg = sg16; n = q16.size();
        end else begin
            w = 32; iv = iv32; ir = ir32; ov = ov32; ordy = ordy32; o = out32;
            ofl = ofl32; co = co32; z = z32; a = a32; b = b32;
            ci = cin32; op = op32; ia = ia32; ib = ib32; sg = sg32; n = q32.size();
        end
        if (ov) begin
            if (n == 0) begin
                chk($sformatf("w%0d_unexpected_out", w), {31'd0, ov}, 32'd0);
            end else begin
                e = (d == 0) ? q16[0] : q32[0];
                chk($sformatf("w%0d_out", w), o, e[31:0]);
                chk($sformatf("w%0d_z", w), {31'd0, z}, {31'd0, e[32]});
                chk($sformatf("w%0d_cout", w), {31'd0, co}, {31'd0, e[33]});
                chk($sformatf("w%0d_ofl", w), {31'd0, ofl}, {31'd0, e[34]});
                if (ordy) begin
                    if (d == 0) void'(q16.pop_front()); else void'(q32.pop_front());
                end
            end
        end
        if (rst) begin
            chk($sformatf("w%0d_in_ready_rst", w), {31'd0, ir}, 32'd0);
            if (d == 0) q16.delete(); else q32.delete();
        end else if (iv && ir) begin
            e = model(w, a, b, ci, op, ia, ib, sg);
            if (d == 0) q16.push_back(e); else q32.push_back(e);
        end
        if (d == 0) acc16 = iv && ir; else acc32 = iv && ir;
    endtask

    task automatic step();
        #1;
        mon(0);
        mon(1);
        @(negedge clk);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic [2:0] op, input logic ia, input logic ib, input logic sg);
        iv16 = 1'b1; a16 = a; b16 = b; cin16 = ci; op16 = op; ia16 = ia; ib16 = ib; sg16 = sg;
        step();
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        #1;
        chk("rst_out_valid", {31'd0, ov16}, 32'd0);
        chk("rst_out", {16'h0, out16}, 32'd0);
        chk("rst_flags", {29'd0, ofl16, co16, z16}, 32'd0);
        chk("rst_out_valid32", {31'd0, ov32}, 32'd0);
        rst = 1'b0; ordy16 = 1'b1; ordy32 = 1'b1;

        // Signed overflow on ADD and its two-cycle latency.
        issue16(16'h7FFF, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1);
        iv16 = 1'b0;
        #1 chk("lat_edge1_valid", {31'd0, ov16}, 32'd0);
        step();
        #1 chk("lat_edge2_valid", {31'd0, ov16}, 32'd1);
        chk("add_ofl_out", {16'h0, out16}, 32'h8000);
        chk("add_ofl_flags", {29'd0, ofl16, co16, z16}, {29'd0, 3'b100});
        step();

        // Subtract by invert-plus-carry.
        issue16(16'h0005, 16'h0005, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1);
        iv16 = 1'b0;
        step();
        #1 chk("sub_out", {16'h0, out16}, 32'h0000);
        chk("sub_flags", {29'd0, ofl16, co16, z16}, {29'd0, 3'b011});
        step();

        // Back-to-back shifts, including sh=0 with upper B bits set.
        issue16(16'h8001, 16'h0004, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        issue16(16'h8000, 16'h000F, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        #1 chk("rot_out", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'h0018});
        issue16(16'h8000, 16'h0F0F, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
        #1 chk("asr_out", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'hFFFF});
        issue16(16'hABCD, 16'h0010, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
        #1 chk("lsr_out", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'h0001});
        iv16 = 1'b0;
        step();
        #1 chk("lsl_sh0_out", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'hABCD});
        step(); step();

        // Backpressure: third bundle must be refused and the first result held.
        ordy16 = 1'b0;
        iv16 = 1'b1; a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0; op16 = 3'b100; ia16 = 1'b0; ib16 = 1'b0; sg16 = 1'b0;
        #1 chk("bp_ready1", {31'd0, ir16}, 32'd1);
        step();
        a16 = 16'h00F0; b16 = 16'h0F00; op16 = 3'b101;
        #1 chk("bp_ready2", {31'd0, ir16}, 32'd1);
        step();
        a16 = 16'hFFFF; b16 = 16'h00FF; op16 = 3'b110;
        #1 chk("bp_ready3", {31'd0, ir16}, 32'd0);
        step();
        #1 chk("bp_hold1", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'h0003});
        step();
        #1 chk("bp_hold2", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'h0003});
        ordy16 = 1'b1;
        step();
        iv16 = 1'b0;
        #1 chk("bp_second", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'h0FF0});
        step();
        #1 chk("bp_third", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'hFF00});
        step(); step();
        chk("bp_drained", 32'(q16.size()), 32'd0);

        // Reset with both stages full.
        ordy16 = 1'b0;
        issue16(16'h1111, 16'h2222, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        issue16(16'h3333, 16'h4444, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        iv16 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; ordy16 = 1'b1;
        #1 chk("rst_mid_valid", {31'd0, ov16}, 32'd0);
        issue16(16'h1234, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        iv16 = 1'b0;
        #1 chk("post_rst_empty", {31'd0, ov16}, 32'd0);
        step();
        #1 chk("post_rst_out", {15'd0, ov16, out16}, {15'd0, 1'b1, 16'h1235});
        step();
        #1 chk("post_rst_no_stale", {31'd0, ov16}, 32'd0);
        step();

        // 32-bit unsigned wrap.
        iv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; op32 = 3'b100; ia32 = 1'b0; ib32 = 1'b0; sg32 = 1'b0;
        step();
        iv32 = 1'b0;
        step();
        #1 chk("w32_wrap_out", out32, 32'h0000_0000);
        chk("w32_wrap_flags", {28'd0, ov32, ofl32, co32, z32}, {28'd0, 4'b1111});
        step();

        // Randomized traffic with backpressure and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            if (!(iv16 && !acc16)) begin
                iv16 = ($urandom_range(0, 9) < 7);
                a16 = 16'($urandom);
                b16 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
                cin16 = 1'($urandom); op16 = 3'($urandom); ia16 = 1'($urandom);
                ib16 = 1'($urandom); sg16 = 1'($urandom);
            end
            if (!(iv32 && !acc32)) begin
                iv32 = ($urandom_range(0, 9) < 7);
                a32 = $urandom;
                b32 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
                cin32 = 1'($urandom); op32 = 3'($urandom); ia32 = 1'($urandom);
                ib32 = 1'($urandom); sg32 = 1'($urandom);
            end
            ordy16 = ($urandom_range(0, 9) < 7);
            ordy32 = ($urandom_range(0, 9) < 7);
            step();
        end

        rst = 1'b0; iv16 = 1'b0; iv32 = 1'b0; ordy16 = 1'b1; ordy32 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("final_drain16", 32'(q16.size()), 32'd0);
        chk("final_drain32", 32'(q32.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
